ground_scroller: RTL and testbench

- Parametrised successor to the fixed 40x8 ground strip renderer.
- Renders a horizontally scrolling, run-time loadable ground pattern band on the VGA scan. Generalised pattern width/height, band position and speed.
- Adds a run/halt/idle state machine, frame-synchronous (tear-free) scrolling and a pattern write port.
- Sits between the VGA timing generator and the pixel mux. Collision logic reads `ground_position` and `speed`.

---
 rtl/ground_pkg.sv | 44 ++++
 rtl/ground_pattern_ram.sv | 53 +++++
 rtl/ground_scroller.sv | 163 ++++++++++++++++
 tb/tb_ground_scroller.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ground_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ground_pkg
// Description : Shared types, default parameter values and helper functions
//               for the scrolling ground renderer.
//               - state_t           : run-control state encoding
//               - default_row_fill  : reset pattern generator (per-row fill bit)
//               - wrap_add          : single-subtract modular addition
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package ground_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam int c_pat_w       = 40;
   localparam int c_pat_rows    = 8;
   localparam int c_y_top       = 400;
   localparam int c_speed_w     = 4;
   localparam int c_speed_init  = 4;
   localparam int c_speed_max   = 12;
   localparam int c_tick_frames = 1;
   localparam int c_ramp_steps  = 256;
   localparam int c_line_row    = 2;

   // Reset contents: the line row is solid, every other row is blank.
   function automatic logic default_row_fill(input int row, input int line_row);
      return (row == line_row);
   endfunction

   // (a + b) mod m for a, b < m: one conditional subtract is enough.
   function automatic int unsigned wrap_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned m);
      int unsigned s;
      s = a + b;
      return (s >= m) ? (s - m) : s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ground_pattern_ram.sv
`default_nettype none
// ============================================================================
// Module      : ground_pattern_ram
// Description : PAT_ROWS x PAT_W pattern store. Synchronous write,
//               combinational row read, asynchronous reset to the default
//               pattern (row LINE_ROW all ones, others zero).
// Ports       : clk    - pixel clock
//               N_rst  - asynchronous active-low reset
//               we     - write strobe (already qualified by the caller)
//               waddr  - write row index; out-of-range indices are ignored
//               wdata  - write row data, bit 0 = leftmost pixel
//               raddr  - read row index
//               rdata  - read row data (zero for out-of-range index)
// Revision    : 1.0 - initial release
// ============================================================================
module ground_pattern_ram
   import ground_pkg::*;
#(
   parameter int PAT_W    = c_pat_w,
   parameter int PAT_ROWS = c_pat_rows,
   parameter int LINE_ROW = c_line_row,
   parameter int ROW_W    = (PAT_ROWS > 1) ? $clog2(PAT_ROWS) : 1
) (
   input  logic             clk,
   input  logic             N_rst,
   input  logic             we,
   input  logic [ROW_W-1:0] waddr,
   input  logic [PAT_W-1:0] wdata,
   input  logic [ROW_W-1:0] raddr,
   output logic [PAT_W-1:0] rdata
);

   logic [PAT_W-1:0] r_mem [PAT_ROWS];

   always_ff @(posedge clk or negedge N_rst) begin
      if (!N_rst) begin
         for (int i = 0; i < PAT_ROWS; i++) begin
            r_mem[i] <= {PAT_W{default_row_fill(i, LINE_ROW)}};
         end
      end else if (we && (32'(waddr) < PAT_ROWS)) begin
         r_mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      if (32'(raddr) < PAT_ROWS) begin
         rdata = r_mem[raddr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/ground_scroller.sv
`default_nettype none
// ============================================================================
// Module      : ground_scroller
// Description : Horizontally scrolling ground band for the VGA scan.
//               IDLE/RUN/HALT control, frame-synchronous position update,
//               run-time loadable pattern (writable in IDLE only).
//               Optional macro GROUND_SPEED_RAMP_EN: speed increases by one
//               every RAMP_STEPS position updates, saturating at SPEED_MAX.
// Ports       : clk             - pixel clock (clkdiv[0])
//               N_rst           - asynchronous active-low reset
//               game_status     - 1 = game running
//               restart         - pulse, leaves HALT
//               frame_start     - pulse at start of vertical blank
//               row_addr        - current scan line
//               col_addr        - current pixel column
//               pat_we/pat_row/pat_data - pattern row write port
//               ground_position - current scroll offset
//               speed           - current scroll speed
//               px              - registered ground pixel (1 cycle latency)
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module ground_scroller
   import ground_pkg::*;
#(
   parameter int PAT_W       = c_pat_w,
   parameter int PAT_ROWS    = c_pat_rows,
   parameter int Y_TOP       = c_y_top,
   parameter int SPEED_W     = c_speed_w,
   parameter int SPEED_INIT  = c_speed_init,
   parameter int SPEED_MAX   = c_speed_max,
   parameter int TICK_FRAMES = c_tick_frames,
   parameter int RAMP_STEPS  = c_ramp_steps,
   parameter int LINE_ROW    = c_line_row,
   parameter int ROW_W       = (PAT_ROWS > 1) ? $clog2(PAT_ROWS) : 1,
   parameter int POS_W       = $clog2(PAT_W)
) (
   input  logic               clk,
   input  logic               N_rst,
   input  logic               game_status,
   input  logic               restart,
   input  logic               frame_start,
   input  logic [8:0]         row_addr,
   input  logic [9:0]         col_addr,
   input  logic               pat_we,
   input  logic [ROW_W-1:0]   pat_row,
   input  logic [PAT_W-1:0]   pat_data,
   output logic [POS_W-1:0]   ground_position,
   output logic [SPEED_W-1:0] speed,
   output logic               px
);

   localparam int FCNT_W = $clog2(TICK_FRAMES + 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [POS_W-1:0]   r_pos;
   logic [SPEED_W-1:0] r_speed;
   logic [FCNT_W-1:0]  r_fcnt;
   logic               r_px;
   logic               w_tick;
   logic               w_scroll_frame;
   logic [PAT_W-1:0]   w_row_data;
   logic [9:0]         w_row10;
   logic               w_in_band;
   logic [POS_W-1:0]   w_col_mod;
   logic [POS_W-1:0]   w_idx;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge N_rst) begin
      if (!N_rst) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (game_status)  w_next_state = RUN;
         RUN:     if (!game_status) w_next_state = HALT;
         HALT:    if (restart)      w_next_state = IDLE;
         default:                   w_next_state = IDLE;
      endcase
   end

   // ---------------------------------------------------------- scrolling
   // A frame only counts while staying in RUN, so a transition on the same
   // cycle as frame_start suppresses the update.
   assign w_scroll_frame = (r_state == RUN) && (w_next_state == RUN) && frame_start;
   assign w_tick         = (r_fcnt == FCNT_W'(TICK_FRAMES - 1));

`ifdef GROUND_SPEED_RAMP_EN
   localparam int RAMP_W = $clog2(RAMP_STEPS + 1);
   logic [RAMP_W-1:0] r_ramp;
`endif

   always_ff @(posedge clk or negedge N_rst) begin
      if (!N_rst) begin
         r_pos   <= '0;
         r_speed <= SPEED_W'(SPEED_INIT);
         r_fcnt  <= '0;
`ifdef GROUND_SPEED_RAMP_EN
         r_ramp  <= '0;
`endif
      end else if ((r_state == HALT) && restart) begin
         r_pos   <= '0;
         r_speed <= SPEED_W'(SPEED_INIT);
         r_fcnt  <= '0;
`ifdef GROUND_SPEED_RAMP_EN
         r_ramp  <= '0;
`endif
      end else if (w_scroll_frame) begin
         if (w_tick) begin
            r_fcnt <= '0;
            r_pos  <= POS_W'(wrap_add(32'(r_pos), 32'(r_speed), PAT_W));
`ifdef GROUND_SPEED_RAMP_EN
            if (r_ramp == RAMP_W'(RAMP_STEPS - 1)) begin
               r_ramp <= '0;
               if (r_speed < SPEED_W'(SPEED_MAX)) r_speed <= r_speed + 1'b1;
            end else begin
               r_ramp <= r_ramp + 1'b1;
            end
`endif
         end else begin
            r_fcnt <= r_fcnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------ pattern store
   ground_pattern_ram #(
      .PAT_W    (PAT_W),
      .PAT_ROWS (PAT_ROWS),
      .LINE_ROW (LINE_ROW),
      .ROW_W    (ROW_W)
   ) u_ram (
      .clk   (clk),
      .N_rst (N_rst),
      .we    (pat_we && (r_state == IDLE)),
      .waddr (pat_row),
      .wdata (pat_data),
      .raddr (ROW_W'(w_row10 - 10'(Y_TOP))),
      .rdata (w_row_data)
   );

   // --------------------------------------------------------- pixel path
   assign w_row10   = {1'b0, row_addr};
   assign w_in_band = (r_state != IDLE) &&
                      (w_row10 >= 10'(Y_TOP)) &&
                      (w_row10 <  10'(Y_TOP + PAT_ROWS));
   // Column is reduced first so the index wraps inside the row.
   assign w_col_mod = POS_W'(32'(col_addr) % PAT_W);
   assign w_idx     = POS_W'(wrap_add(32'(w_col_mod), 32'(r_pos), PAT_W));

   always_ff @(posedge clk or negedge N_rst) begin
      if (!N_rst) r_px <= 1'b0;
      else        r_px <= w_in_band ? w_row_data[w_idx] : 1'b0;
   end

   assign ground_position = r_pos;
   assign speed           = r_speed;
   assign px              = r_px;

endmodule
`default_nettype wire

// File: tb/tb_ground_scroller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ground_scroller
// Description : Scoreboard bench for ground_scroller. Stimulus pushes the
//               expected value and raises a sample strobe; the monitor pops
//               and compares on the following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ground_scroller;

    localparam int c_k_px    = 0;
    localparam int c_k_pos   = 1;
    localparam int c_k_speed = 2;

`ifdef GROUND_SPEED_RAMP_EN
    localparam int c_ramp_steps = 2;
    localparam int c_speed_max  = 6;
`else
    localparam int c_ramp_steps = 256;
    localparam int c_speed_max  = 12;
`endif

    logic        clk = 1'b0;
    logic        N_rst = 1'b0;
    logic        game_status = 1'b0;
    logic        restart = 1'b0;
    logic        frame_start = 1'b0;
    logic [8:0]  row_addr = '0;
    logic [9:0]  col_addr = '0;
    logic        pat_we = 1'b0;
    logic [2:0]  pat_row = '0;
    logic [39:0] pat_data = '0;
    logic [5:0]  ground_position;
    logic [3:0]  speed;
    logic        px;

    always #5 clk = ~clk;

    ground_scroller #(
        .RAMP_STEPS (c_ramp_steps),
        .SPEED_MAX  (c_speed_max)
    ) dut (
        .clk             (clk),
        .N_rst           (N_rst),
        .game_status     (game_status),
        .restart         (restart),
        .frame_start     (frame_start),
        .row_addr        (row_addr),
        .col_addr        (col_addr),
        .pat_we          (pat_we),
        .pat_row         (pat_row),
        .pat_data        (pat_data),
        .ground_position (ground_position),
        .speed           (speed),
        .px              (px)
    );

    typedef struct {
        int    kind;
        int    exp;
        string name;
    } exp_t;

    exp_t  sb[$];
    exp_t  cur;
    logic  sample = 1'b0;
    int    n_pass = 0;
    int    n_total = 0;
    int    act;

    // reference scroll state
    int m_pos = 0;
    int m_speed = 4;
    int m_ramp = 0;

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (sample) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL scoreboard_underflow: actual empty queue, required an entry");
            end else begin
                cur = sb.pop_front();
                case (cur.kind)
                    c_k_px:  act = int'(px);
                    c_k_pos: act = int'(ground_position);
                    default: act = int'(speed);
                endcase
                if (act == cur.exp) n_pass++;
                else $display("FAIL %s: actual %0d, required %0d", cur.name, act, cur.exp);
            end
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input int kind, input int exp, input string name);
        sb.push_back('{kind, exp, name});
        sample = 1'b1;
        step(1);
        sample = 1'b0;
    endtask

    task automatic scan(input int r, input int c, input int exp, input string name);
        row_addr = 9'(r);
        col_addr = 10'(c);
        step(1);
        chk(c_k_px, exp, name);
    endtask

    task automatic model_update();
        m_pos = (m_pos + m_speed) % 40;
`ifdef GROUND_SPEED_RAMP_EN
        m_ramp++;
        if (m_ramp == c_ramp_steps) begin
            m_ramp = 0;
            if (m_speed < c_speed_max) m_speed++;
        end
`endif
    endtask

    task automatic pulse(input bit upd);
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        if (upd) model_update();
    endtask

    // ----------------------------------------------------------- watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ----------------------------------------------------------- stimulus
    initial begin
        step(3);
        N_rst = 1'b1;
        step(1);
        chk(c_k_pos,   0, "reset_pos");
        chk(c_k_speed, 4, "reset_speed");
        scan(402, 0, 0, "idle_px_blank");

        // custom row 0: only the leftmost pixel set
        pat_row  = 3'd0;
        pat_data = 40'd1;
        pat_we   = 1'b1;
        step(1);
        pat_we   = 1'b0;

        game_status = 1'b1;
        step(1);
        scan(400,  0, 1, "run_col0");
        scan(400, 40, 1, "run_col40");
        scan(400, 80, 1, "run_col80");
        scan(400,  1, 0, "run_col1");
        scan(402, 17, 1, "line_row");
        scan(399,  0, 0, "above_band");
        scan(408,  0, 0, "below_band");

        // writes outside IDLE are dropped
        pat_data = '1;
        pat_we   = 1'b1;
        step(1);
        pat_we   = 1'b0;
        scan(400, 1, 0, "run_write_ignored");

        for (int i = 0; i < 12; i++) begin
            step(97);
            pulse(1'b1);
            chk(c_k_pos,   m_pos,   "scroll_pos");
            chk(c_k_speed, m_speed, "scroll_speed");
            if (i == 0) begin
                scan(400, (40 - m_pos) % 40, 1, "scrolled_px_hit");
                scan(400, 0, 0, "scrolled_px_miss");
            end
        end

        // stop on the same cycle as frame_start: no update
        game_status = 1'b0;
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        chk(c_k_pos, m_pos, "halt_same_cycle_pos");
        scan(402, 3, 1, "halt_draws_line");
        scan(400, (40 - m_pos) % 40, 1, "halt_frozen_px");
        game_status = 1'b1;
        pulse(1'b0);
        chk(c_k_pos, m_pos, "halt_frame_ignored");

        game_status = 1'b0;
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        m_pos = 0; m_speed = 4; m_ramp = 0;
        chk(c_k_pos,   0, "restart_pos");
        chk(c_k_speed, 4, "restart_speed");
        scan(402, 0, 0, "restart_idle_px");

        // run again, then asynchronous reset mid-scan
        game_status = 1'b1;
        step(1);
        pulse(1'b1);
        chk(c_k_pos, m_pos, "rerun_pos");
        scan(400, (40 - m_pos) % 40, 1, "custom_pattern_kept");
        N_rst = 1'b0;
        chk(c_k_px,  0, "async_rst_px");
        chk(c_k_pos, 0, "async_rst_pos");
        N_rst = 1'b1;
        m_pos = 0; m_speed = 4; m_ramp = 0;
        step(1);
        scan(400, 0, 0, "default_pattern_restored");
        scan(402, 36, 1, "default_line_row");

        step(3);
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: actual %0d left, required 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
